// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared state encoding, field select codes and BCD limits for the clock
package clk_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HOUR = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_SEC  = 2'd3;

    localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
    localparam logic [7:0] BCD_MS_MAX   = 8'h59;

endpackage

// File: rtl/bcd_step.sv
// rtl/bcd_step.sv - combinational two-digit BCD +/-1 with wrap at a programmable maximum
module bcd_step (
    input  logic [7:0] value,
    input  logic [7:0] max,
    input  logic       dec,
    output logic [7:0] result
);

    always_comb begin
        result = value;
        if (dec) begin
            if (value == 8'h00)
                result = max;
            else if (value[3:0] == 4'h0)
                result = {value[7:4] - 4'h1, 4'h9};
            else
                result = {value[7:4], value[3:0] - 4'h1};
        end else begin
            if (value == max)
                result = 8'h00;
            else if (value[3:0] == 4'h9)
                result = {value[7:4] + 4'h1, 4'h0};
            else
                result = {value[7:4], value[3:0] + 4'h1};
        end
    end

endmodule

// File: rtl/clock_time_set.sv
// rtl/clock_time_set.sv - time-setting controller driving the BCD counters' load/data/enable
// Optional decrement key enabled by defining TIME_SET_DEC_EN.
module clock_time_set
    import clk_pkg::*;
#(
    parameter logic [7:0] HOUR_MAX = BCD_HOUR_MAX,
    parameter logic [7:0] MS_MAX   = BCD_MS_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
`ifdef TIME_SET_DEC_EN
    input  logic       key_dec,
`endif
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic       run_en,
    output logic       load_h,
    output logic       load_m,
    output logic       load_s,
    output logic [7:0] hour_data,
    output logic [7:0] min_data,
    output logic [7:0] sec_data,
    output logic [1:0] sel
);

    state_t     state;
    logic       step_inc;
    logic       step_dec;
    logic       step;
    logic [7:0] step_in;
    logic [7:0] step_max;
    logic [7:0] step_out;

`ifdef TIME_SET_DEC_EN
    // Simultaneous inc and dec cancel each other out.
    assign step_inc = key_inc & ~key_dec;
    assign step_dec = key_dec & ~key_inc;
`else
    assign step_inc = key_inc;
    assign step_dec = 1'b0;
`endif

    assign step   = (state != RUN) && !key_mode && (step_inc || step_dec);
    assign run_en = (state == RUN) && !key_mode;

    always_comb begin
        step_in  = hour_data;
        step_max = HOUR_MAX;
        case (state)
            SET_M:   begin step_in = min_data; step_max = MS_MAX; end
            SET_S:   begin step_in = sec_data; step_max = MS_MAX; end
            default: begin step_in = hour_data; step_max = HOUR_MAX; end
        endcase
    end

    bcd_step u_bcd_step (
        .value  (step_in),
        .max    (step_max),
        .dec    (step_dec),
        .result (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            sel       <= SEL_NONE;
            load_h    <= 1'b0;
            load_m    <= 1'b0;
            load_s    <= 1'b0;
            hour_data <= 8'h00;
            min_data  <= 8'h00;
            sec_data  <= 8'h00;
        end else begin
            load_h <= 1'b0;
            load_m <= 1'b0;
            load_s <= 1'b0;
            if (key_mode) begin
                case (state)
                    RUN: begin
                        state     <= SET_H;
                        sel       <= SEL_HOUR;
                        hour_data <= cur_hour;
                        min_data  <= cur_min;
                        sec_data  <= cur_sec;
                    end
                    SET_H: begin
                        state <= SET_M;
                        sel   <= SEL_MIN;
                    end
                    SET_M: begin
                        state <= SET_S;
                        sel   <= SEL_SEC;
                    end
                    SET_S: begin
                        state  <= RUN;
                        sel    <= SEL_NONE;
                        load_h <= 1'b1;
                        load_m <= 1'b1;
                        load_s <= 1'b1;
                    end
                endcase
            end else if (step) begin
                case (state)
                    SET_H:   hour_data <= step_out;
                    SET_M:   min_data  <= step_out;
                    SET_S:   sec_data  <= step_out;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_time_set.sv
// tb/tb_clock_time_set.sv - table-driven scoreboard bench for clock_time_set
module tb_clock_time_set;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_mode, key_inc, key_dec;
    logic [7:0] cur_hour, cur_min, cur_sec;
    logic       run_en, load_h, load_m, load_s;
    logic [7:0] hour_data, min_data, sec_data;
    logic [1:0] sel;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       mode, inc, dec;
        logic [7:0] ch, cm, cs;
        logic       e_run;
        logic [1:0] e_sel;
        logic       e_load;
        logic [7:0] e_h, e_m, e_s;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    clock_time_set dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
`ifdef TIME_SET_DEC_EN
        .key_dec   (key_dec),
`endif
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .run_en    (run_en),
        .load_h    (load_h),
        .load_m    (load_m),
        .load_s    (load_s),
        .hour_data (hour_data),
        .min_data  (min_data),
        .sec_data  (sec_data),
        .sel       (sel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mode, input logic inc, input logic dec,
                                input logic [23:0] cur, input logic e_run, input logic [1:0] e_sel,
                                input logic e_load, input logic [23:0] e_time);
        vec_t v;
        v.mode = mode; v.inc = inc; v.dec = dec;
        v.ch = cur[23:16]; v.cm = cur[15:8]; v.cs = cur[7:0];
        v.e_run = e_run; v.e_sel = e_sel; v.e_load = e_load;
        v.e_h = e_time[23:16]; v.e_m = e_time[15:8]; v.e_s = e_time[7:0];
        return v;
    endfunction

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        key_mode = v.mode; key_inc = v.inc; key_dec = v.dec;
        cur_hour = v.ch; cur_min = v.cm; cur_sec = v.cs;
        #1;
        check($sformatf("v%0d run_en", idx), {31'd0, run_en}, {31'd0, v.e_run});
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d sel", idx), {30'd0, sel}, {30'd0, e.e_sel});
        check($sformatf("v%0d load", idx), {29'd0, load_h, load_m, load_s}, {29'd0, {3{e.e_load}}});
        check($sformatf("v%0d data", idx), {8'd0, hour_data, min_data, sec_data},
              {8'd0, e.e_h, e.e_m, e.e_s});
        key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
        cur_hour = 8'h00; cur_min = 8'h00; cur_sec = 8'h00;

        //            mode inc dec cur        run sel load shadows
        vecs.push_back(mk(0, 0, 0, 24'h123456, 1, 0, 0, 24'h000000));
        vecs.push_back(mk(0, 1, 0, 24'h123456, 1, 0, 0, 24'h000000));
        vecs.push_back(mk(1, 0, 0, 24'h123456, 0, 1, 0, 24'h123456));
        vecs.push_back(mk(0, 1, 0, 24'h123456, 0, 1, 0, 24'h133456));
        vecs.push_back(mk(1, 1, 0, 24'h123456, 0, 2, 0, 24'h133456));
        vecs.push_back(mk(0, 1, 0, 24'h123456, 0, 2, 0, 24'h133556));
        vecs.push_back(mk(1, 0, 0, 24'h123456, 0, 3, 0, 24'h133556));
        vecs.push_back(mk(0, 1, 0, 24'h123456, 0, 3, 0, 24'h133557));
        vecs.push_back(mk(1, 0, 0, 24'h123456, 0, 0, 1, 24'h133557));
        vecs.push_back(mk(0, 0, 0, 24'h123456, 1, 0, 0, 24'h133557));
        vecs.push_back(mk(1, 0, 0, 24'h220959, 0, 1, 0, 24'h220959));
        vecs.push_back(mk(0, 1, 0, 24'h220959, 0, 1, 0, 24'h230959));
        vecs.push_back(mk(0, 1, 0, 24'h220959, 0, 1, 0, 24'h000959));
        vecs.push_back(mk(0, 1, 0, 24'h220959, 0, 1, 0, 24'h010959));
        vecs.push_back(mk(1, 0, 0, 24'h220959, 0, 2, 0, 24'h010959));
        vecs.push_back(mk(0, 1, 0, 24'h220959, 0, 2, 0, 24'h011059));
        vecs.push_back(mk(1, 0, 0, 24'h220959, 0, 3, 0, 24'h011059));
        vecs.push_back(mk(0, 1, 0, 24'h220959, 0, 3, 0, 24'h011000));
        vecs.push_back(mk(1, 0, 0, 24'h220959, 0, 0, 1, 24'h011000));
        vecs.push_back(mk(1, 0, 0, 24'h220959, 0, 1, 0, 24'h220959));
        vecs.push_back(mk(1, 0, 0, 24'h220959, 0, 2, 0, 24'h220959));
        vecs.push_back(mk(1, 0, 0, 24'h220959, 0, 3, 0, 24'h220959));
        vecs.push_back(mk(1, 0, 0, 24'h220959, 0, 0, 1, 24'h220959));
        vecs.push_back(mk(0, 0, 0, 24'h220959, 1, 0, 0, 24'h220959));
`ifdef TIME_SET_DEC_EN
        vecs.push_back(mk(1, 0, 0, 24'h001000, 0, 1, 0, 24'h001000));
        vecs.push_back(mk(0, 0, 1, 24'h001000, 0, 1, 0, 24'h231000));
        vecs.push_back(mk(0, 1, 1, 24'h001000, 0, 1, 0, 24'h231000));
        vecs.push_back(mk(1, 0, 1, 24'h001000, 0, 2, 0, 24'h231000));
        vecs.push_back(mk(0, 0, 1, 24'h001000, 0, 2, 0, 24'h230900));
        vecs.push_back(mk(1, 0, 0, 24'h001000, 0, 3, 0, 24'h230900));
        vecs.push_back(mk(0, 0, 1, 24'h001000, 0, 3, 0, 24'h230959));
        vecs.push_back(mk(1, 0, 0, 24'h001000, 0, 0, 1, 24'h230959));
        vecs.push_back(mk(0, 0, 0, 24'h001000, 1, 0, 0, 24'h230959));
`endif

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        foreach (vecs[i]) apply(i, vecs[i]);

        // Reset in the middle of an edit: immediate return to RUN, shadows cleared, no load.
        cur_hour = 8'h12; cur_min = 8'h34; cur_sec = 8'h56;
        key_mode = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        key_mode = 1'b0;
        check("pre_reset sel", {30'd0, sel}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset sel", {30'd0, sel}, 32'd0);
        check("mid_reset load", {29'd0, load_h, load_m, load_s}, 32'd0);
        check("mid_reset data", {8'd0, hour_data, min_data, sec_data}, 32'd0);
        check("mid_reset run_en", {31'd0, run_en}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset c%0d load", c), {29'd0, load_h, load_m, load_s}, 32'd0);
            check($sformatf("post_reset c%0d sel", c), {30'd0, sel}, 32'd0);
        end

        check("scoreboard empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
